// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the default character width.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter side signals of the UART transmit arbiter,
// bundled for benches and surrounding glue.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = 4
) ();

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_enable;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_ready;
    logic                          tx_start;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic [IDX_W-1:0]              grant_id;
    logic                          busy;

    modport master (
        output req_valid, req_last, req_data, req_enable, tx_ready,
        input  req_ready, tx_start, tx_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, req_enable, tx_ready,
        output req_ready, tx_start, tx_data, grant_id, busy
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: the first set request strictly after
// ptr (wrapping) wins; outputs are all-zero when nothing is requested.
module uart_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         onehot,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SW    = IDX_W + 1;

    logic [SW-1:0]    sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan the requesters in rotating order starting one past the pointer.
    always_comb begin
        onehot  = '0;
        idx     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum_s = {1'b0, ptr} + SW'(k);
            if (sum_s >= SW'(NUM_REQ)) begin
                cand_s = IDX_W'(sum_s - SW'(NUM_REQ));
            end else begin
                cand_s = sum_s[IDX_W-1:0];
            end
            if (!found_s && req[cand_s]) begin
                found_s        = 1'b1;
                onehot[cand_s] = 1'b1;
                idx            = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources with round-robin
// grants, packet lock and a per-grant burst limit.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_enable,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t                state_r, state_nxt;
    logic [IDX_W-1:0]      grant_id_r, ptr_r, pick_idx_s;
    logic [NUM_REQ-1:0]    pick_onehot_s, grant_onehot_s, req_ready_r;
    logic [CNT_W-1:0]      burst_cnt_r, burst_inc_s;
    logic                  last_r, tx_start_r, busy_r;
    logic [DATA_WIDTH-1:0] tx_data_r;
    logic                  grant_s, send_s, done_s, release_s;
    logic [DATA_WIDTH-1:0] slice_s [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice_s[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req_valid & req_enable),
        .ptr    (ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s)
    );

    // Next-state decode; the grant is only re-arbitrated from IDLE.
    always_comb begin
        state_nxt      = state_r;
        grant_s        = 1'b0;
        send_s         = 1'b0;
        done_s         = 1'b0;
        release_s      = 1'b0;
        grant_onehot_s = '0;
        grant_onehot_s[grant_id_r] = 1'b1;
        if (burst_cnt_r == CNT_W'(MAX_BURST)) begin
            burst_inc_s = burst_cnt_r;
        end else begin
            burst_inc_s = burst_cnt_r + CNT_W'(1);
        end
        case (state_r)
            IDLE: begin
                if (|pick_onehot_s) begin
                    grant_s   = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (!req_enable[grant_id_r]) begin
                    release_s = 1'b1;
                    state_nxt = IDLE;
                end else if (tx_ready && req_valid[grant_id_r]) begin
                    send_s    = 1'b1;
                    state_nxt = WAIT_ACK;
                end else begin
                    state_nxt = LOAD;
                end
            end
            WAIT_ACK: begin
                if (!tx_ready) begin
                    state_nxt = WAIT_DONE;
                end else begin
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    done_s = 1'b1;
                    if (last_r || (burst_inc_s == CNT_W'(MAX_BURST))) begin
                        release_s = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end else begin
                    state_nxt = WAIT_DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            grant_id_r  <= '0;
            ptr_r       <= IDX_W'(NUM_REQ - 1);
            burst_cnt_r <= '0;
            last_r      <= 1'b0;
            tx_start_r  <= 1'b0;
            tx_data_r   <= '0;
            req_ready_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            busy_r     <= (state_nxt != IDLE);
            tx_start_r <= send_s;
            if (send_s) begin
                req_ready_r <= grant_onehot_s;
                tx_data_r   <= slice_s[grant_id_r];
                last_r      <= req_last[grant_id_r];
            end else begin
                req_ready_r <= '0;
            end
            if (grant_s) begin
                grant_id_r  <= pick_idx_s;
                burst_cnt_r <= '0;
            end else if (done_s) begin
                burst_cnt_r <= burst_inc_s;
            end
            if (release_s) begin
                ptr_r <= grant_id_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign grant_id  = grant_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued requester models, a
// transmitter model and a scoreboard of expected {grantee, byte} sends.
module tb_uart_tx_arbiter;

    localparam int DW      = 8;
    localparam int NR      = 4;
    localparam int MB      = 4;
    localparam int TX_BUSY = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) ifc ();

    uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (ifc.req_valid),
        .req_last   (ifc.req_last),
        .req_data   (ifc.req_data),
        .req_enable (ifc.req_enable),
        .req_ready  (ifc.req_ready),
        .tx_ready   (ifc.tx_ready),
        .tx_start   (ifc.tx_start),
        .tx_data    (ifc.tx_data),
        .grant_id   (ifc.grant_id),
        .busy       (ifc.busy)
    );

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int ready_cnt [NR];
    int gap = 100;
    int tx_cnt = 0;
    logic [8:0] rq [NR][$];
    logic [9:0] sb [$];
    logic [9:0] mon_exp;
    logic [3:0] mon_rdy;

    typedef struct {
        int         r;
        logic [3:0] en;
        logic [7:0] data;
        bit         send;
    } vec_t;
    vec_t vecs [6];

    // Transmitter: busy for TX_BUSY cycles after each frame start.
    always @(posedge clk) begin
        if (ifc.tx_start) begin
            tx_cnt       <= TX_BUSY;
            ifc.tx_ready <= 1'b0;
        end else if (tx_cnt > 1) begin
            tx_cnt <= tx_cnt - 1;
        end else begin
            tx_cnt       <= 0;
            ifc.tx_ready <= 1'b1;
        end
    end

    // Requesters: present the queue head, pop it on an accept pulse.
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (ifc.req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                ifc.req_valid[i]          <= 1'b1;
                ifc.req_last[i]           <= rq[i][0][8];
                ifc.req_data[i*DW +: DW]  <= rq[i][0][7:0];
            end else begin
                ifc.req_valid[i]          <= 1'b0;
                ifc.req_last[i]           <= 1'b0;
                ifc.req_data[i*DW +: DW]  <= 8'h00;
            end
        end
    end

    // Monitor: every frame start is matched against the scoreboard.
    initial begin
        for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) if (ifc.req_ready[i]) ready_cnt[i]++;
            if (ifc.tx_start) begin
                start_cnt++;
                checks++;
                if (ifc.tx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_busy_start: tx_start=1 with tx_ready=%b, required tx_ready=1", ifc.tx_ready);
                end
                checks++;
                if (gap < 3) begin
                    errors++;
                    $display("FAIL start_spacing: gap %0d cycles, required >= 3", gap);
                end
                gap = 1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_send: grant_id=%0d tx_data=%h, no send expected", ifc.grant_id, ifc.tx_data);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({ifc.grant_id, ifc.tx_data} !== mon_exp) begin
                        errors++;
                        $display("FAIL send: got gid=%0d data=%h, required gid=%0d data=%h",
                                 ifc.grant_id, ifc.tx_data, mon_exp[9:8], mon_exp[7:0]);
                    end
                    mon_rdy = 4'b0001 << mon_exp[9:8];
                    checks++;
                    if (ifc.req_ready !== mon_rdy) begin
                        errors++;
                        $display("FAIL req_ready: got %b, required %b", ifc.req_ready, mon_rdy);
                    end
                end
            end else begin
                if (gap < 1000) gap++;
                if (ifc.req_ready !== 4'b0000) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_ready: req_ready=%b without tx_start, required 0000", ifc.req_ready);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l, input bit exp);
        rq[r].push_back({l, d});
        if (exp) sb.push_back({2'(r), d});
    endtask

    task automatic wait_for(input string name, input bit need_idle, input int budget);
        int n;
        n = 0;
        while (n < budget &&
               !(sb.size() == 0 && (!need_idle || (!ifc.busy && ifc.tx_ready === 1'b1)))) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, %0d sends outstanding, required 0", name, n, sb.size());
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tx_start"},  32'(ifc.tx_start),  32'h0);
        chk({tag, "_req_ready"}, 32'(ifc.req_ready), 32'h0);
        chk({tag, "_tx_data"},   32'(ifc.tx_data),   32'h0);
        chk({tag, "_grant_id"},  32'(ifc.grant_id),  32'h0);
        chk({tag, "_busy"},      32'(ifc.busy),      32'h0);
    endtask

    initial begin
        int s0;
        int r0;
        vecs[0] = '{0, 4'hF, 8'hA5, 1'b1};
        vecs[1] = '{2, 4'hF, 8'h3C, 1'b1};
        vecs[2] = '{1, 4'hF, 8'h00, 1'b1};
        vecs[3] = '{3, 4'hF, 8'hFF, 1'b1};
        vecs[4] = '{0, 4'hE, 8'h5A, 1'b0};
        vecs[5] = '{3, 4'h7, 8'h77, 1'b0};

        ifc.req_enable = 4'hF;
        rst_n = 1'b0;
        cycles(3);
        chk_reset("reset");
        rst_n = 1'b1;
        cycles(2);

        // Single-byte packets, with and without the requester masked.
        for (int v = 0; v < 6; v++) begin
            ifc.req_enable = vecs[v].en;
            s0 = start_cnt;
            r0 = ready_cnt[vecs[v].r];
            push(vecs[v].r, vecs[v].data, 1'b1, vecs[v].send);
            if (vecs[v].send) begin
                wait_for("vec_done", 1'b1, 300);
                chk("vec_starts",   32'(start_cnt - s0),                 32'd1);
                chk("vec_ready",    32'(ready_cnt[vecs[v].r] - r0),      32'd1);
                chk("vec_grant_id", 32'(ifc.grant_id),                   32'(vecs[v].r));
                chk("vec_tx_data",  32'(ifc.tx_data),                    32'(vecs[v].data));
                chk("vec_busy",     32'(ifc.busy),                       32'h0);
            end else begin
                cycles(15);
                chk("mask_starts", 32'(start_cnt - s0), 32'd0);
                chk("mask_busy",   32'(ifc.busy),       32'h0);
                rq[vecs[v].r].delete();
                cycles(2);
            end
            ifc.req_enable = 4'hF;
        end

        // Contention, last grant was requester 3: expect 0,1,2,3,0.
        s0 = start_cnt;
        push(0, 8'h10, 1'b1, 1'b1);
        push(1, 8'h21, 1'b1, 1'b1);
        push(2, 8'h32, 1'b1, 1'b1);
        push(3, 8'h43, 1'b1, 1'b1);
        push(0, 8'h11, 1'b1, 1'b1);
        wait_for("contention", 1'b1, 1000);
        chk("contention_starts", 32'(start_cnt - s0), 32'd5);

        // Packet lock: three bytes from 1 before 2 gets in.
        push(1, 8'hB1, 1'b0, 1'b1);
        push(1, 8'hB2, 1'b0, 1'b1);
        push(1, 8'hB3, 1'b1, 1'b1);
        push(2, 8'hC1, 1'b1, 1'b1);
        wait_for("packet_lock", 1'b1, 1000);

        // Stall in LOAD: grantee 0 has no byte, requester 3 must stay out.
        push(0, 8'hD1, 1'b0, 1'b1);
        wait_for("stall_first", 1'b0, 300);
        push(3, 8'hE1, 1'b1, 1'b0);
        s0 = start_cnt;
        cycles(40);
        chk("stall_starts", 32'(start_cnt - s0), 32'd0);
        chk("stall_busy",   32'(ifc.busy),       32'h1);
        chk("stall_grant",  32'(ifc.grant_id),   32'h0);
        push(0, 8'hD2, 1'b1, 1'b1);
        sb.push_back({2'd3, 8'hE1});
        wait_for("stall_release", 1'b1, 300);

        // Burst limit of 4, then release of a stalled grant via req_enable.
        for (int b = 0; b < 4; b++) push(0, 8'h80 + 8'(b), 1'b0, 1'b1);
        push(3, 8'hE2, 1'b1, 1'b1);
        push(0, 8'h84, 1'b0, 1'b0);
        push(0, 8'h85, 1'b0, 1'b0);
        sb.push_back({2'd0, 8'h84});
        sb.push_back({2'd0, 8'h85});
        wait_for("burst", 1'b0, 1000);
        cycles(30);
        chk("burst_stall_busy",  32'(ifc.busy),     32'h1);
        chk("burst_stall_grant", 32'(ifc.grant_id), 32'h0);
        s0 = start_cnt;
        ifc.req_enable = 4'hE;
        cycles(3);
        chk("disable_release_busy", 32'(ifc.busy),       32'h0);
        chk("disable_no_start",     32'(start_cnt - s0), 32'd0);
        ifc.req_enable = 4'hF;
        cycles(2);

        // Reset while waiting for the transmitter to finish.
        push(1, 8'h91, 1'b0, 1'b1);
        push(1, 8'h92, 1'b1, 1'b0);
        wait_for("pre_reset", 1'b0, 300);
        cycles(5);
        push(0, 8'hF0, 1'b1, 1'b0);
        rst_n = 1'b0;
        cycles(1);
        chk_reset("midrst");
        rst_n = 1'b1;
        sb.delete();
        sb.push_back({2'd0, 8'hF0});
        sb.push_back({2'd1, 8'h92});
        wait_for("post_reset", 1'b1, 500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 8: the character width.
REQ-002 Parameter NUM_REQ SHALL default to 4: the number of requesters (2..8).
REQ-003 Parameter MAX_BURST SHALL default to 16: the maximum bytes sent under one grant.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n SHALL be an input, 1 bit: reset, synchronous and active-low.
REQ-006 Port req_valid SHALL be an input, NUM_REQ bits: a per-requester byte is available.
REQ-007 Port req_last SHALL be an input, NUM_REQ bits: the per-requester byte ends its packet.
REQ-008 Port req_data SHALL be an input, NUM_REQ*DATA_WIDTH bits: requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port req_enable SHALL be an input, NUM_REQ bits: a requester with its bit at 0 is never granted.
REQ-010 Port req_ready SHALL be an output, NUM_REQ bits: a one-hot, one-cycle byte-accept pulse.
REQ-011 Port tx_ready SHALL be an input, 1 bit: the transmitter is idle.
REQ-012 Port tx_start SHALL be an output, 1 bit: a one-cycle frame-start pulse to the transmitter.
REQ-013 Port tx_data SHALL be an output, DATA_WIDTH bits: the byte presented with tx_start.
REQ-014 Port grant_id SHALL be an output, $clog2(NUM_REQ) bits: the current or most recent grantee.
REQ-015 Port busy SHALL be an output, 1 bit: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, WAIT_ACK and WAIT_DONE.
REQ-017 In IDLE, if any bit of (req_valid & req_enable) is set, the block SHALL grant round-robin, starting from the requester after the last grantee, register grant_id, clear burst_cnt and go to LOAD.
REQ-018 In LOAD, when tx_ready=1 and req_valid[grant_id]=1, the block SHALL, for exactly one cycle, assert tx_start, assert req_ready[grant_id] and drive tx_data from the grantee slice, then go to WAIT_ACK.
REQ-019 The block SHALL register tx_data and hold it until the next tx_start.
REQ-020 The block SHALL latch req_last[grant_id] at the moment req_ready pulses.
REQ-021 In LOAD with req_valid[grant_id]=0, the block SHALL hold the grant (packet lock), drive no tx_start, and allow no other requester in.
REQ-022 In WAIT_ACK, the block SHALL wait for tx_ready=0 and then go to WAIT_DONE.
REQ-023 In WAIT_DONE, on tx_ready=1 the block SHALL increment burst_cnt.
REQ-024 Leaving WAIT_DONE, if the latched last=1 or burst_cnt reaches MAX_BURST, the block SHALL go to IDLE and update the round-robin pointer to grant_id; otherwise it SHALL go to LOAD.
REQ-025 Deasserting req_enable[grant_id] mid-packet SHALL be honoured only in LOAD: the block SHALL release to IDLE without sending.
REQ-026 At most one req_ready bit and one tx_start SHALL be active per byte, and never outside LOAD.
REQ-027 Minimum spacing between tx_start pulses SHALL be 3 cycles.
REQ-028 Requester i with valid held SHALL be granted within NUM_REQ-1 releases of other grants.
REQ-029 burst_cnt SHALL be $clog2(MAX_BURST+1) bits and SHALL never wrap.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL go to IDLE with tx_start=0, req_ready=0, tx_data=0, grant_id=0, busy=0, burst_cnt=0, and the round-robin pointer set to NUM_REQ-1, so requester 0 wins first.
REQ-031 Reset mid-packet SHALL abort the grant with no further tx_start; a frame already started in the transmitter is not recalled.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state typedef and the default DATA_WIDTH constant.
REQ-033 Sub-module uart_rr_pick SHALL be the round-robin selector: request vector plus pointer in, one-hot and index out, purely combinational.

Verification
REQ-034 Single request: req_valid=0001, data 0xA5, last=1, tx_ready model 20 cycles busy -> one tx_start, tx_data=0xA5, grant_id=0, req_ready=0001 once, busy low afterwards.
REQ-035 Contention: all four valid, each sending 1-byte packets continuously -> grants in the order 0,1,2,3,0, with no back-to-back grants to the same requester.
REQ-036 Packet lock: requester 1 sends 3 bytes (last on the third) while requester 2 is valid -> bytes 1,1,1 are sent, then requester 2 is granted.
REQ-037 Burst limit: MAX_BURST=4, requester 0 sends 6 bytes with last never set, requester 3 is valid -> after 4 bytes, grant moves to 3, then returns to 0.
REQ-038 Mask and stall: req_enable=1110 with req_valid=0001 -> no tx_start; with a grantee stalled in LOAD, other requesters stay blocked.
REQ-039 Reset mid-packet: rst_n low for 1 cycle in WAIT_DONE -> all outputs at their reset values next cycle, and the next grant goes to requester 0.
